// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the byte-serial FP multiplier.
package fp_mul_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        UNLOAD  = 2'd2
    } state_t;

    // Bit positions inside the 3-bit status flag vector
    localparam int FLG_UNF = 0;
    localparam int FLG_OVF = 1;
    localparam int FLG_INV = 2;

    localparam logic MODE_EXACT    = 1'b0;
    localparam logic MODE_MITCHELL = 1'b1;

endpackage

// File: rtl/fp_mul_core.sv
// Combinational FP multiply: exact (truncated) and Mitchell log-approximate
// datapaths plus zero/inf/NaN/overflow/underflow handling.
module fp_mul_core
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    localparam int W    = 1 + EXP_W + MAN_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         mode,
    output logic [W-1:0] result,
    output logic [2:0]   flags
);

    localparam int EW2  = EXP_W + 2;
    localparam int BIAS = 2**(EXP_W-1) - 1;
    localparam logic signed [EW2-1:0] BIAS_S = EW2'(BIAS);
    localparam logic signed [EW2-1:0] E_OVF  = EW2'(2**EXP_W - 1);
    localparam logic [EXP_W-1:0]      E_ONES = '1;

    logic             sa, sb, s;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;

    assign sa = a[W-1];
    assign sb = b[W-1];
    assign ea = a[W-2:MAN_W];
    assign eb = b[W-2:MAN_W];
    assign ma = a[MAN_W-1:0];
    assign mb = b[MAN_W-1:0];
    assign s  = sa ^ sb;

    logic a_ones, b_ones, a_zero, b_zero, a_nan, b_nan;

    assign a_ones = (ea == E_ONES);
    assign b_ones = (eb == E_ONES);
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_nan  = a_ones && (ma != '0);
    assign b_nan  = b_ones && (mb != '0);

    // Both datapaths are always computed; mode only picks the mantissa/carry
    logic [2*MAN_W+1:0] prod;
    logic [MAN_W:0]     msum;

    assign prod = {1'b1, ma} * {1'b1, mb};
    assign msum = ma + mb;

    logic             c;
    logic [MAN_W-1:0] m;

    // Mantissa and exponent carry: normalise the product by its top bit, or
    // take the carry out of the log-domain mantissa sum
    always_comb begin
        c = 1'b0;
        m = '0;
        if (mode == MODE_MITCHELL) begin
            c = msum[MAN_W];
            m = msum[MAN_W-1:0];
        end else if (prod[2*MAN_W+1]) begin
            c = 1'b1;
            m = prod[2*MAN_W:MAN_W+1];
        end else begin
            c = 1'b0;
            m = prod[2*MAN_W-1:MAN_W];
        end
    end

    // Signed with two guard bits so both overflow and underflow are visible
    logic signed [EW2-1:0] e_int;

    assign e_int = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S
                 + $signed({{(EW2-1){1'b0}}, c});

    // Special cases in priority order, then the normal packed result
    always_comb begin
        result = {s, e_int[EXP_W-1:0], m};
        flags  = '0;
        if (a_nan || b_nan || (a_zero && b_ones) || (b_zero && a_ones)) begin
            result         = {1'b0, E_ONES, 1'b1, {(MAN_W-1){1'b0}}};
            flags[FLG_INV] = 1'b1;
        end else if (a_ones || b_ones) begin
            result = {s, E_ONES, {MAN_W{1'b0}}};
        end else if (a_zero || b_zero) begin
            result = {s, {(W-1){1'b0}}};
        end else if (e_int >= E_OVF) begin
            result         = {s, E_ONES, {MAN_W{1'b0}}};
            flags[FLG_OVF] = 1'b1;
        end else if (e_int <= 0) begin
            result         = {s, {(W-1){1'b0}}};
            flags[FLG_UNF] = 1'b1;
        end
    end

endmodule

// File: rtl/fp_serial_mul.sv
// Byte-serial FP multiplier: LOAD gathers operand bytes LSB first, COMPUTE
// registers the product, UNLOAD streams result bytes with valid/ready.
module fp_serial_mul
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       mode,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a_byte,
    input  logic [7:0] b_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_byte,
    output logic       out_last,
    output logic [2:0] flags
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int NB    = (W + 7) / 8;
    localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NB - 1);

    state_t state, state_nxt;

    logic [CNT_W-1:0]    cnt;
    logic [NB-1:0][7:0]  a_reg, b_reg, res_pad;
    logic [NB*8-1:0]     a_flat, b_flat;
    logic                mode_reg;
    logic [W-1:0]        res_reg, core_res;
    logic [2:0]          flg_reg, core_flg;
    logic                in_fire, out_fire;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Padding bits of the last operand byte never reach the core
    assign a_flat  = a_reg;
    assign b_flat  = b_reg;
    assign res_pad = (NB*8)'(res_reg);

    fp_mul_core #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_core (
        .a      (a_flat[W-1:0]),
        .b      (b_flat[W-1:0]),
        .mode   (mode_reg),
        .result (core_res),
        .flags  (core_flg)
    );

    // State register; reset wins over ena, ena=0 freezes
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= LOAD;
        else if (ena)
            state <= state_nxt;
    end

    // Next-state: advance on the final byte handshake in each direction
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (in_fire && cnt == LAST)  state_nxt = COMPUTE;
            COMPUTE: state_nxt = UNLOAD;
            UNLOAD:  if (out_fire && cnt == LAST) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // Handshake and output byte decode; out_byte is zero outside UNLOAD
    always_comb begin
        in_ready  = ena && (state == LOAD);
        out_valid = ena && (state == UNLOAD);
        out_byte  = '0;
        out_last  = 1'b0;
        if (state == UNLOAD) begin
            out_byte = res_pad[cnt];
            out_last = (cnt == LAST);
        end
    end

    assign flags = flg_reg;

    // Byte counter, operand capture and result/flag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            mode_reg <= MODE_EXACT;
            res_reg  <= '0;
            flg_reg  <= '0;
        end else if (ena) begin
            case (state)
                LOAD: if (in_fire) begin
                    a_reg[cnt] <= a_byte;
                    b_reg[cnt] <= b_byte;
                    if (cnt == '0)
                        mode_reg <= mode;
                    cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
                end
                COMPUTE: begin
                    res_reg <= core_res;
                    flg_reg <= core_flg;
                    cnt     <= '0;
                end
                UNLOAD: if (out_fire) begin
                    cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_serial_mul.sv
// Scoreboard bench for fp_serial_mul (EXP_W=5, MAN_W=10, two bytes/operand).
module tb_fp_serial_mul;

    localparam int NB = 2;

    logic       clk = 1'b0;
    logic       rst_n, ena, mode, in_valid, in_ready;
    logic       out_valid, out_ready, out_last;
    logic [7:0] a_byte, b_byte, out_byte;
    logic [2:0] flags;

    fp_serial_mul #(.EXP_W(5), .MAN_W(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_byte    (a_byte),
        .b_byte    (b_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_last  (out_last),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [2:0] flg;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out", name);
    endtask

    task automatic expect_frame(input logic [15:0] r, input logic [2:0] f);
        exp_t e;
        for (int i = 0; i < NB; i++) begin
            e.data = r[i*8 +: 8];
            e.last = (i == NB-1);
            e.flg  = f;
            sb.push_back(e);
        end
    endtask

    // Present both operands LSB byte first; returns just after the last accept
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic m);
        int n;
        for (int i = 0; i < NB; i++) begin
            a_byte   = a[i*8 +: 8];
            b_byte   = b[i*8 +: 8];
            mode     = m;
            in_valid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 200) begin
                n++;
                @(negedge clk);
            end
            if (!in_ready) timeout("send");
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!out_valid) timeout("wait_valid");
    endtask

    task automatic wait_empty();
        int n = 0;
        @(negedge clk);
        while (sb.size() != 0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (sb.size() != 0) timeout("wait_empty");
        @(posedge clk); #1;
    endtask

    // Monitor: every accepted output byte is compared against the queue head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte actual=%0h required=none", out_byte);
                end else begin
                    e = sb.pop_front();
                    chk("out_byte", 32'(out_byte), 32'(e.data));
                    chk("out_last", 32'(out_last), 32'(e.last));
                    chk("flags",    32'(flags),    32'(e.flg));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ena = 1'b1; mode = 1'b0; in_valid = 1'b0;
        a_byte = '0; b_byte = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_byte",  32'(out_byte),  0);
        chk("rst_out_last",  32'(out_last),  0);
        chk("rst_flags",     32'(flags),     0);
        @(posedge clk); #1;

        // Exact 1.5*1.5 = 2.25, with latency check
        expect_frame(16'h4080, 3'b000);
        send(16'h3E00, 16'h3E00, 1'b0);
        @(negedge clk);
        chk("lat_compute_valid", 32'(out_valid), 0);
        @(negedge clk);
        chk("lat_unload_valid",  32'(out_valid), 1);
        wait_empty();

        // Mitchell 1.5*1.5 ~ 2.0
        expect_frame(16'h4000, 3'b000);
        send(16'h3E00, 16'h3E00, 1'b1);
        wait_empty();

        // 3.0 * -2.0 in both modes
        expect_frame(16'hC600, 3'b000);
        send(16'h4200, 16'hC000, 1'b0);
        wait_empty();
        expect_frame(16'hC600, 3'b000);
        send(16'h4200, 16'hC000, 1'b1);
        wait_empty();

        // Overflow, underflow, 0*inf
        expect_frame(16'h7C00, 3'b010);
        send(16'h7BFF, 16'h7BFF, 1'b0);
        wait_empty();
        expect_frame(16'h0000, 3'b001);
        send(16'h0400, 16'h0400, 1'b0);
        wait_empty();
        expect_frame(16'h7E00, 3'b100);
        send(16'h0000, 16'h7C00, 1'b0);
        wait_empty();

        // Backpressure: first byte held for 3 cycles
        out_ready = 1'b0;
        expect_frame(16'h4080, 3'b000);
        send(16'h3E00, 16'h3E00, 1'b0);
        wait_valid();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_byte",  32'(out_byte),  32'h80);
            chk("bp_last",  32'(out_last),  0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        wait_empty();

        // ena low between input bytes and again mid-UNLOAD
        out_ready = 1'b0;
        expect_frame(16'hC600, 3'b000);
        a_byte = 8'h00; b_byte = 8'h00; mode = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        if (!in_ready) timeout("ena_first_byte");
        @(posedge clk); #1;
        ena = 1'b0; a_byte = 8'h42; b_byte = 8'hC0;
        repeat (4) begin
            @(negedge clk);
            chk("ena_in_ready",  32'(in_ready),  0);
            chk("ena_out_valid", 32'(out_valid), 0);
        end
        @(posedge clk); #1 ena = 1'b1;
        @(negedge clk);
        if (!in_ready) timeout("ena_second_byte");
        @(posedge clk); #1 in_valid = 1'b0;
        wait_valid();
        @(posedge clk); #1 ena = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("ena_unl_valid", 32'(out_valid), 0);
            chk("ena_unl_ready", 32'(in_ready),  0);
            chk("ena_unl_byte",  32'(out_byte),  32'h00);
        end
        @(posedge clk); #1 ena = 1'b1; out_ready = 1'b1;
        wait_empty();

        // Reset during UNLOAD discards the frame
        out_ready = 1'b0;
        send(16'h7BFF, 16'h7BFF, 1'b0);
        wait_valid();
        chk("pre_rst_flags", 32'(flags), 32'b010);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_ready", 32'(in_ready),  1);
        chk("mid_rst_flags", 32'(flags),     0);
        @(posedge clk); #1 out_ready = 1'b1;
        expect_frame(16'h4000, 3'b000);
        send(16'h3C00, 16'h4000, 1'b0);
        wait_empty();

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
